// File: rtl/draw_scheduler_pkg.sv
// draw_scheduler_pkg: shared field widths and FSM state type for the draw scheduler.
package draw_pkg;
   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;
   typedef enum logic [2:0] {S_IDLE, S_ARB, S_GRANT, S_RELEASE, S_DONE} state_t;
endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: client/VGA bundle between game logic (master) and the scheduler (slave).
interface draw_scheduler_if import draw_pkg::*; #(parameter int NUM_CLIENTS = 3);
   logic                         frame_start;
   logic [NUM_CLIENTS-1:0]       req;
   logic [NUM_CLIENTS*X_W-1:0]   client_x;
   logic [NUM_CLIENTS*Y_W-1:0]   client_y;
   logic [NUM_CLIENTS*C_W-1:0]   client_color;
   logic [NUM_CLIENTS-1:0]       client_finish;
   logic [NUM_CLIENTS-1:0]       draw;
   logic [X_W-1:0]               vga_x;
   logic [Y_W-1:0]               vga_y;
   logic [C_W-1:0]               vga_color;
   logic                         vga_plot;
   logic                         busy;
   logic                         frame_done;
   logic                         overrun;
   logic                         timeout;
   modport master (
      output frame_start, req, client_x, client_y, client_color, client_finish,
      input  draw, vga_x, vga_y, vga_color, vga_plot, busy, frame_done, overrun, timeout
   );
   modport slave (
      input  frame_start, req, client_x, client_y, client_color, client_finish,
      output draw, vga_x, vga_y, vga_color, vga_plot, busy, frame_done, overrun, timeout
   );
endinterface

// File: rtl/draw_scheduler_rr_picker.sv
// rr_picker: first set bit of pending at or above rr_ptr, wrapping round to bit 0.
module rr_picker #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  pending,
   input  logic [IW-1:0] rr_ptr,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      idx = '0;
      any = |pending;
      // scan from the far end so the smallest offset from rr_ptr wins
      for (int o = N - 1; o >= 0; o--) begin
         if (pending[(int'(rr_ptr) + o) % N]) idx = IW'((int'(rr_ptr) + o) % N);
      end
   end
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame round-robin arbiter for the VGA pixel-write port.
// Optional grant watchdog enabled by defining DRAW_WDOG_EN.
module draw_scheduler import draw_pkg::*; #(
   parameter int NUM_CLIENTS = 3,
   parameter int WDOG_CYCLES = 4096
) (
   input logic             clock,
   input logic             reset,
   draw_scheduler_if.slave bus
);
   localparam int IW = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;
   if (NUM_CLIENTS < 1 || NUM_CLIENTS > 8 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad
      $error("draw_scheduler: parameter out of range");
   end
   state_t                 state;
   logic [NUM_CLIENTS-1:0] pending;
   logic [IW-1:0]          rr_ptr, grant, pick;
   logic                   any, fin, wdog_hit;
   logic                   busy, frame_done, overrun;
   logic [X_W-1:0]         cur_x, last_x;
   logic [Y_W-1:0]         cur_y, last_y;
   logic [C_W-1:0]         cur_c, last_c;
   rr_picker #(.N(NUM_CLIENTS), .IW(IW)) u_pick (
      .pending(pending),
      .rr_ptr (rr_ptr),
      .idx    (pick),
      .any    (any)
   );
   assign fin   = bus.client_finish[grant];
   assign cur_x = bus.client_x[int'(grant) * X_W +: X_W];
   assign cur_y = bus.client_y[int'(grant) * Y_W +: Y_W];
   assign cur_c = bus.client_color[int'(grant) * C_W +: C_W];
`ifdef DRAW_WDOG_EN
   logic [15:0] wdog;
   logic        tmo;
   assign wdog_hit = wdog == 16'(WDOG_CYCLES - 1);
   always_ff @(posedge clock) begin
      if (reset) begin
         wdog <= '0;
         tmo  <= 1'b0;
      end else begin
         wdog <= state == S_GRANT ? wdog + 16'd1 : '0;
         if (state == S_GRANT && wdog_hit && !fin) tmo <= 1'b1;
      end
   end
   assign bus.timeout = tmo;
`else
   assign wdog_hit    = 1'b0;
   assign bus.timeout = 1'b0;
`endif
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         pending    <= '0;
         rr_ptr     <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         last_x     <= '0;
         last_y     <= '0;
         last_c     <= '0;
      end else begin
         frame_done <= state == S_DONE;
         if (bus.frame_start && state != S_IDLE) overrun <= 1'b1;
         case (state)
            S_IDLE: if (bus.frame_start) begin
               pending <= bus.req;
               busy    <= 1'b1;
               state   <= S_ARB;
            end
            S_ARB: begin
               grant <= pick;
               state <= any ? S_GRANT : S_DONE;
            end
            S_GRANT: begin
               last_x <= cur_x;
               last_y <= cur_y;
               last_c <= cur_c;
               if (fin || wdog_hit) state <= S_RELEASE;
            end
            S_RELEASE: begin
               pending[grant] <= 1'b0;
               rr_ptr         <= grant == IW'(NUM_CLIENTS - 1) ? '0 : grant + 1'b1;
               state          <= S_ARB;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   assign bus.draw       = state == S_GRANT ? NUM_CLIENTS'(1) << grant : '0;
   assign bus.vga_plot   = state == S_GRANT && !fin;
   assign bus.vga_x      = state == S_GRANT ? cur_x : last_x;
   assign bus.vga_y      = state == S_GRANT ? cur_y : last_y;
   assign bus.vga_color  = state == S_GRANT ? cur_c : last_c;
   assign bus.busy       = busy;
   assign bus.frame_done = frame_done;
   assign bus.overrun    = overrun;
endmodule
